mat_mul_seq: RTL

- Sequencing controller for the matrix-multiply datapath: three single-port BRAMs (A, B, R) and one MAC unit.
- Accepts A then B as one AXI-Stream packet and generates BRAM enable, write-enable and address for every element product.
- Drives MAC clear/accumulate, writes each result element to R, then streams R out on the AXI-Stream master.
- Sits between the AXI-Lite start register, both AXI-Stream ports and the BRAM/MAC datapath. It touches no data, only control.

---
 rtl/mat_mul_seq_if.sv | 9 +
 rtl/mat_mul_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mat_mul_seq_if.sv
// AXI-Stream handshake bundle (valid/last/ready) used on both stream ports of mat_mul_seq.
interface mat_mul_seq_if;
    logic tvalid;
    logic tlast;
    logic tready;

    modport master (output tvalid, output tlast, input tready);
    modport slave  (input tvalid, input tlast, output tready);
endinterface

// File: rtl/mat_mul_seq.sv
// Control sequencer for the matrix-multiply datapath: loads A/B from the input stream,
// steps BRAM/MAC through every element product, writes R and streams R back out.
module mat_mul_seq #(
    parameter int DIM_LOG  = 1,
    parameter int DIM      = 2**DIM_LOG,
    parameter int SIZE     = DIM*DIM,
    parameter int SIZE_LOG = 2*DIM_LOG
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_areset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    mat_mul_seq_if.slave        s00_axis,
    mat_mul_seq_if.master       m00_axis,
    output logic                en_A,
    output logic                we_A,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic                en_B,
    output logic                we_B,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic                en_R,
    output logic                we_R,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic                mac_en,
    output logic                mac_first
);
    localparam logic [SIZE_LOG-1:0] CNT_LAST = SIZE_LOG'(SIZE-1);
    localparam logic [DIM_LOG-1:0]  IDX_LAST = DIM_LOG'(DIM-1);

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, CALC, DRAIN, WRITE, OUT_RD, OUT_VAL, DONE
    } state_t;

    state_t              state, state_d;
    logic [SIZE_LOG-1:0] cnt;
    logic [DIM_LOG-1:0]  i, j, k;
    logic                in_beat, cnt_last, elem_last;

    assign in_beat   = s00_axis.tvalid & s00_axis.tready;
    assign cnt_last  = (cnt == CNT_LAST);
    assign elem_last = (i == IDX_LAST) && (j == IDX_LAST);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) state <= IDLE;
        else                state <= state_d;
    end

    always_comb begin
        state_d = state;
        en_A    = 1'b0;
        we_A    = 1'b0;
        addr_A  = '0;
        en_B    = 1'b0;
        we_B    = 1'b0;
        addr_B  = '0;
        en_R    = 1'b0;
        we_R    = 1'b0;
        addr_R  = '0;
        case (state)
            IDLE:   if (start) state_d = LOAD_A;
            LOAD_A: if (in_beat) begin
                en_A   = 1'b1;
                we_A   = 1'b1;
                addr_A = cnt;
                if (cnt_last) state_d = LOAD_B;
            end
            LOAD_B: if (in_beat) begin
                en_B   = 1'b1;
                we_B   = 1'b1;
                addr_B = cnt;
                if (cnt_last) state_d = CALC;
            end
            CALC: begin
                en_A   = 1'b1;
                en_B   = 1'b1;
                addr_A = {i, k};
                addr_B = {k, j};
                if (k == IDX_LAST) state_d = DRAIN;
            end
            DRAIN:  state_d = WRITE;
            WRITE: begin
                en_R    = 1'b1;
                we_R    = 1'b1;
                addr_R  = {i, j};
                state_d = elem_last ? OUT_RD : CALC;
            end
            OUT_RD: begin
                en_R    = 1'b1;
                addr_R  = cnt;
                state_d = OUT_VAL;
            end
            OUT_VAL: begin
                // address held with en_R low so BRAM output stays on the beat
                addr_R = cnt;
                if (m00_axis.tready) state_d = cnt_last ? DONE : OUT_RD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            cnt <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt <= '0;
                    err <= 1'b0;
                end
                LOAD_A: if (in_beat) begin
                    cnt <= cnt_last ? '0 : cnt + SIZE_LOG'(1);
                    if (s00_axis.tlast) err <= 1'b1;
                end
                LOAD_B: if (in_beat) begin
                    // tlast is legal only on the final B beat
                    if (s00_axis.tlast != cnt_last) err <= 1'b1;
                    if (cnt_last) begin
                        cnt <= '0;
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                    end else begin
                        cnt <= cnt + SIZE_LOG'(1);
                    end
                end
                CALC: k <= k + DIM_LOG'(1);
                WRITE: begin
                    k <= '0;
                    j <= j + DIM_LOG'(1);
                    if (j == IDX_LAST) i <= i + DIM_LOG'(1);
                    if (elem_last) cnt <= '0;
                end
                OUT_VAL: if (m00_axis.tready && !cnt_last) cnt <= cnt + SIZE_LOG'(1);
                default: ;
            endcase
        end
    end

    // MAC controls trail the BRAM read issue by the one-cycle read latency
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            s00_axis.tready <= 1'b0;
            m00_axis.tvalid <= 1'b0;
            m00_axis.tlast  <= 1'b0;
            mac_en          <= 1'b0;
            mac_first       <= 1'b0;
        end else begin
            s00_axis.tready <= (state_d == LOAD_A) || (state_d == LOAD_B);
            m00_axis.tvalid <= (state_d == OUT_VAL);
            m00_axis.tlast  <= (state_d == OUT_VAL) && cnt_last;
            mac_en          <= (state == CALC);
            mac_first       <= (state == CALC) && (k == '0);
        end
    end
endmodule
